llc_snoop_responder: RTL and testbench
======================================

Name: llc_snoop_responder

Overview:
- Snoop-side counterpart of the LLC's bus-initiator model. It accepts one snooped bus operation at a time from another cache, looks up the local tag/MESI store and drives the snoop result (HIT/HITM/NOHIT).
- On HITM it performs the line writeback handshake and commits the MESI transition.
- It sits between the shared system bus and the LLC tag array's read/update ports.

Parameters:
- ADDR_W, 32, physical address width
- OFF_BITS, 6, byte-offset bits (64 B line)
- SET_BITS, 14, index bits (16384 sets)
- WAYS, 16, associativity; WAY_BITS = $clog2(WAYS)
- TAG_W, ADDR_W-SET_BITS-OFF_BITS, tag width (derived, not overridable)
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- snp_valid  in  1  snoop request valid
- snp_ready  out  1  high only in IDLE
- snp_op  in  2  bus_op_e: READ=0, WRITE=1, RWIM=2, INVALIDATE=3
- snp_addr  in  ADDR_W  snooped address
- lk_req  out  1  tag lookup strobe, one cycle
- lk_index  out  SET_BITS  lookup set index
- lk_tag  out  TAG_W  lookup tag
- lk_rsp_valid  in  1  lookup response, exactly one cycle after lk_req
- lk_hit  in  1  tag match on a valid line
- lk_way  in  WAY_BITS  matching way
- lk_mesi  in  2  mesi_states_e of the matching line
- res_valid  out  1  snoop result strobe, one cycle
- res  out  2  snoop_result_e: HIT=0, HITM=1, NOHIT=2
- wb_valid  out  1  writeback request
- wb_ready  in  1  writeback accept
- wb_addr  out  ADDR_W  line-aligned writeback address
- upd_valid  out  1  MESI update strobe, one cycle
- upd_index  out  SET_BITS  set index to update
- upd_way  out  WAY_BITS  way to update
- upd_mesi  out  2  new MESI state
- proto_err  out  1  one-cycle protocol-error pulse
- snp_cnt, hit_cnt, hitm_cnt  out  CNT_W each  saturating statistics

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, all strobes/outputs 0, counters 0. Reset mid-operation abandons the pending writeback and update.
- Address split: index=snp_addr[OFF_BITS +: SET_BITS]; tag=snp_addr[ADDR_W-1 -: TAG_W]; wb_addr = snp_addr with low OFF_BITS zeroed. Address and op are registered on accept and stay stable until return to IDLE.
- FSM: IDLE -> LOOKUP -> EVAL -> RESP -> [WB] -> [UPD] -> IDLE.
- IDLE: snp_ready=1; on snp_valid, latch request, snp_cnt++.
- LOOKUP: lk_req=1 for one cycle; lk_index/lk_tag valid.
- EVAL: sample lk_* responses.
  - If lk_rsp_valid=0, pulse proto_err and treat as a miss.
  - Compute result, next state and wb_need via the transition rules.
- Transition rules:
  - READ: M gives HITM, wb, next S. E gives HIT, next S. S gives HIT, stays S. I/miss gives NOHIT.
  - RWIM: M gives HITM, wb, next I. E/S gives HIT, next I. Miss gives NOHIT.
  - INVALIDATE: S gives HIT, next I. M/E gives NOHIT + proto_err, no change. Miss gives NOHIT.
  - WRITE: hit gives NOHIT + proto_err, no change. Miss gives NOHIT.
- RESP: res_valid=1 for one cycle; hit_cnt++ on HIT, hitm_cnt++ on HITM.
  - Next state is WB if wb_need, else UPD if the state changes, else IDLE.
- WB: hold wb_valid and wb_addr until wb_ready is sampled high. The transfer completes that cycle; next state UPD.
- UPD: upd_valid=1 for one cycle with the latched index, way and new state; next IDLE.
- Nominal latency, accept to res_valid: 3 cycles. No-change ops return to IDLE 4 cycles after accept.
- Counters saturate at all-ones and never wrap.
- snp_valid outside IDLE is ignored; the initiator holds it.

Decomposition:
- Add to cache_struct_pkg: bus_op_e, snoop_result_e, snoop FSM state enum. Reuse the existing mesi_states_e and COUNTER_BITS.
- One combinational sub-module, llc_snoop_mesi_next.
  - Inputs: op, hit, mesi.
  - Outputs: result, next_mesi, wb_need, changed, err.
- The FSM, registers and counters live in the top.

Test Plan:
- READ 0x12345678, lookup hit way 5 in M, wb_ready delayed 3 cycles:
  - res=HITM at cycle 3.
  - wb_addr=0x12345640 held until accepted.
  - Then upd index 0x1159, way 5, S.
  - hitm_cnt=1.
- RWIM same address, line in E:
  - res=HIT, no wb_valid.
  - upd_mesi=I.
  - hit_cnt=1.
- READ, lookup miss:
  - res=NOHIT, no upd_valid.
  - Back in IDLE 4 cycles after accept; snp_cnt=1.
- INVALIDATE on M line, and WRITE on a hit line:
  - res=NOHIT with a proto_err pulse.
  - No update, no writeback.
- rst_n deasserted while in WB with wb_ready=0:
  - All outputs 0 immediately, counters 0.
  - Next snoop is accepted normally.
- Force the counter to all-ones, then issue a HIT snoop: hit_cnt remains all-ones.

Source files
------------

// File: rtl/llc_snoop_responder_pkg.sv
// llc_snoop_responder_pkg: shared enums and constants for the LLC snoop responder
package llc_snoop_responder_pkg;
  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_states_e;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_RWIM = 2'd2, OP_INVALIDATE = 2'd3} bus_op_e;
  typedef enum logic [1:0] {RES_HIT = 2'd0, RES_HITM = 2'd1, RES_NOHIT = 2'd2} snoop_result_e;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_EVAL, S_RESP, S_WB, S_UPD} snoop_state_e;
  localparam int COUNTER_BITS = 32;
endpackage

// File: rtl/llc_snoop_responder_if.sv
// llc_snoop_responder_if: snoop bus, tag lookup, writeback and update signals
interface llc_snoop_responder_if #(
  parameter int ADDR_W = 32,
  parameter int OFF_BITS = 6,
  parameter int SET_BITS = 14,
  parameter int WAYS = 16
);
  import llc_snoop_responder_pkg::*;
  localparam int WAY_BITS = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - SET_BITS - OFF_BITS;
  logic snp_valid, snp_ready;
  bus_op_e snp_op;
  logic [ADDR_W-1:0] snp_addr;
  logic lk_req;
  logic [SET_BITS-1:0] lk_index;
  logic [TAG_W-1:0] lk_tag;
  logic lk_rsp_valid, lk_hit;
  logic [WAY_BITS-1:0] lk_way;
  mesi_states_e lk_mesi;
  logic res_valid;
  snoop_result_e res;
  logic wb_valid, wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic upd_valid;
  logic [SET_BITS-1:0] upd_index;
  logic [WAY_BITS-1:0] upd_way;
  mesi_states_e upd_mesi;
  logic proto_err;
  modport slave (
    input snp_valid, snp_op, snp_addr, lk_rsp_valid, lk_hit, lk_way, lk_mesi, wb_ready,
    output snp_ready, lk_req, lk_index, lk_tag, res_valid, res, wb_valid, wb_addr,
    output upd_valid, upd_index, upd_way, upd_mesi, proto_err
  );
  modport master (
    output snp_valid, snp_op, snp_addr, lk_rsp_valid, lk_hit, lk_way, lk_mesi, wb_ready,
    input snp_ready, lk_req, lk_index, lk_tag, res_valid, res, wb_valid, wb_addr,
    input upd_valid, upd_index, upd_way, upd_mesi, proto_err
  );
endinterface

// File: rtl/llc_snoop_mesi_next.sv
// llc_snoop_mesi_next: snoop result and MESI transition for one snooped op
module llc_snoop_mesi_next
  import llc_snoop_responder_pkg::*;
(
  input bus_op_e op,
  input logic hit,
  input mesi_states_e mesi,
  output snoop_result_e result,
  output mesi_states_e next_mesi,
  output logic wb_need,
  output logic changed,
  output logic err
);
  mesi_states_e m;
  logic rd, rw, inv, wr, valid;
  always_comb begin
    m = hit ? mesi : MESI_I;
    rd = op == OP_READ;
    rw = op == OP_RWIM;
    inv = op == OP_INVALIDATE;
    wr = op == OP_WRITE;
    valid = m != MESI_I;
    wb_need = (rd || rw) && m == MESI_M;
    result = wb_need ? RES_HITM : (((rd || rw) && valid) || (inv && m == MESI_S)) ? RES_HIT : RES_NOHIT;
    next_mesi = (rd && valid) ? MESI_S : (rw || (inv && m == MESI_S)) ? MESI_I : m;
    err = (inv && (m == MESI_M || m == MESI_E)) || (wr && valid);
    changed = next_mesi != m;
  end
endmodule

// File: rtl/llc_snoop_responder.sv
// llc_snoop_responder: snoop lookup, result, writeback and MESI update sequencer
module llc_snoop_responder
  import llc_snoop_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OFF_BITS = 6,
  parameter int SET_BITS = 14,
  parameter int WAYS = 16,
  parameter int CNT_W = COUNTER_BITS
) (
  input logic clk,
  input logic rst_n,
  llc_snoop_responder_if.slave bus,
  output logic [CNT_W-1:0] snp_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] hitm_cnt
);
  localparam int WAY_BITS = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - SET_BITS - OFF_BITS;
  snoop_state_e state, state_nx;
  logic [ADDR_W-OFF_BITS-1:0] line_q;
  bus_op_e op_q;
  logic [WAY_BITS-1:0] way_q;
  snoop_result_e res_q, res_nx;
  mesi_states_e mesi_q, mesi_nx;
  logic wb_q, chg_q, wb_nx, chg_nx, err_nx;
  llc_snoop_mesi_next u_next (
    .op(op_q),
    .hit(bus.lk_rsp_valid && bus.lk_hit),
    .mesi(bus.lk_mesi),
    .result(res_nx),
    .next_mesi(mesi_nx),
    .wb_need(wb_nx),
    .changed(chg_nx),
    .err(err_nx)
  );
  always_comb begin
    state_nx = state;
    bus.snp_ready = state == S_IDLE;
    bus.lk_req = state == S_LOOKUP;
    bus.lk_index = line_q[SET_BITS-1:0];
    bus.lk_tag = line_q[ADDR_W-OFF_BITS-1 -: TAG_W];
    bus.res_valid = state == S_RESP;
    bus.res = res_q;
    bus.wb_valid = state == S_WB;
    bus.wb_addr = {line_q, OFF_BITS'(0)};
    bus.upd_valid = state == S_UPD;
    bus.upd_index = line_q[SET_BITS-1:0];
    bus.upd_way = way_q;
    bus.upd_mesi = mesi_q;
    bus.proto_err = state == S_EVAL && (!bus.lk_rsp_valid || err_nx);
    state_nx = state == S_IDLE ? (bus.snp_valid ? S_LOOKUP : S_IDLE) :
               state == S_LOOKUP ? S_EVAL :
               state == S_EVAL ? S_RESP :
               state == S_RESP ? (wb_q ? S_WB : chg_q ? S_UPD : S_IDLE) :
               state == S_WB ? (bus.wb_ready ? S_UPD : S_WB) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      line_q <= '0;
      op_q <= OP_READ;
      way_q <= '0;
      res_q <= RES_HIT;
      mesi_q <= MESI_I;
      wb_q <= 1'b0;
      chg_q <= 1'b0;
      snp_cnt <= '0;
      hit_cnt <= '0;
      hitm_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.snp_valid) begin
        line_q <= bus.snp_addr[ADDR_W-1:OFF_BITS];
        op_q <= bus.snp_op;
        snp_cnt <= snp_cnt + CNT_W'(~&snp_cnt);
      end
      if (state == S_EVAL) begin
        way_q <= bus.lk_way;
        res_q <= res_nx;
        mesi_q <= mesi_nx;
        wb_q <= wb_nx;
        chg_q <= chg_nx;
      end
      if (state == S_RESP) begin
        hit_cnt <= hit_cnt + CNT_W'(res_q == RES_HIT && ~&hit_cnt);
        hitm_cnt <= hitm_cnt + CNT_W'(res_q == RES_HITM && ~&hitm_cnt);
      end
    end
  end
endmodule

// File: tb/tb_llc_snoop_responder.sv
// tb_llc_snoop_responder: randomized scoreboard bench against a table-driven snoop model
module tb_llc_snoop_responder;
  import llc_snoop_responder_pkg::*;
  localparam int ADDR_W = 32, OFF_BITS = 6, SET_BITS = 14, WAYS = 16, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  typedef struct packed {snoop_result_e res; int cyc;} res_t;
  typedef struct packed {logic [SET_BITS-1:0] idx; logic [3:0] way; mesi_states_e m;} upd_t;
  logic clk = 0, rst_n = 0;
  logic [CNT_W-1:0] snp_cnt, hit_cnt, hitm_cnt;
  int passed = 0, total = 0, cyc = 0, err_seen = 0, wb_wait = 0;
  int m_snp = 0, m_hit = 0, m_hitm = 0;
  logic cur_rv, cur_hit;
  logic [3:0] cur_way;
  mesi_states_e cur_mesi;
  int cur_delay = 0;
  logic [SET_BITS-1:0] cur_idx;
  logic [ADDR_W-SET_BITS-OFF_BITS-1:0] cur_tag;
  res_t exp_res[$];
  logic [ADDR_W-1:0] exp_wb[$];
  upd_t exp_upd[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  llc_snoop_responder_if #(.ADDR_W(ADDR_W), .OFF_BITS(OFF_BITS), .SET_BITS(SET_BITS), .WAYS(WAYS)) bus ();
  llc_snoop_responder #(.ADDR_W(ADDR_W), .OFF_BITS(OFF_BITS), .SET_BITS(SET_BITS), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .snp_cnt(snp_cnt), .hit_cnt(hit_cnt), .hitm_cnt(hitm_cnt)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic int sat(input int v);
    return v >= CMAX ? CMAX : v + 1;
  endfunction
  task automatic model(input bus_op_e op, input logic rv, input logic hit, input mesi_states_e mesi,
                       output snoop_result_e r, output logic wb, output mesi_states_e nm, output logic err);
    mesi_states_e line;
    line = (rv && hit) ? mesi : MESI_I;
    r = RES_NOHIT;
    wb = 0;
    nm = line;
    err = !rv;
    case (op)
      OP_READ: if (line == MESI_M) begin r = RES_HITM; wb = 1; nm = MESI_S; end
               else if (line != MESI_I) begin r = RES_HIT; nm = MESI_S; end
      OP_RWIM: if (line == MESI_M) begin r = RES_HITM; wb = 1; nm = MESI_I; end
               else if (line != MESI_I) begin r = RES_HIT; nm = MESI_I; end
      OP_INVALIDATE: if (line == MESI_S) begin r = RES_HIT; nm = MESI_I; end
                     else if (line != MESI_I) err = 1;
      default: if (line != MESI_I) err = 1;
    endcase
  endtask
  task automatic launch(input bus_op_e op, input logic [ADDR_W-1:0] addr, input logic rv, input logic hit,
                        input logic [3:0] way, input mesi_states_e mesi, input int delay,
                        output logic wb, output logic chg, output logic err);
    snoop_result_e r;
    mesi_states_e nm;
    mesi_states_e line;
    line = (rv && hit) ? mesi : MESI_I;
    model(op, rv, hit, mesi, r, wb, nm, err);
    chg = nm != line;
    cur_rv = rv; cur_hit = hit; cur_way = way; cur_mesi = mesi; cur_delay = delay;
    cur_idx = SET_BITS'(addr >> OFF_BITS);
    cur_tag = addr >> (OFF_BITS + SET_BITS);
    m_snp = sat(m_snp);
    if (r == RES_HIT) m_hit = sat(m_hit);
    if (r == RES_HITM) m_hitm = sat(m_hitm);
    if (wb) exp_wb.push_back(addr & ~32'h3f);
    if (chg) exp_upd.push_back('{idx: cur_idx, way: way, m: nm});
    @(negedge clk);
    check("snp_ready_idle", bus.snp_ready, 1);
    exp_res.push_back('{res: r, cyc: cyc + 3});
    err_seen = 0;
    bus.snp_valid = 1; bus.snp_op = op; bus.snp_addr = addr;
    @(posedge clk);
    #1 bus.snp_valid = 0;
  endtask
  task automatic do_snoop(input bus_op_e op, input logic [ADDR_W-1:0] addr, input logic rv, input logic hit,
                          input logic [3:0] way, input mesi_states_e mesi, input int delay);
    logic wb, chg, err;
    int n;
    launch(op, addr, rv, hit, way, mesi, delay, wb, chg, err);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.snp_ready && n < 100);
    check("idle_latency", n, 4 + (chg ? 1 : 0) + (wb ? delay + 1 : 0));
    check("proto_err_pulses", err_seen, err ? 1 : 0);
    check("snp_cnt", snp_cnt, m_snp);
    check("hit_cnt", hit_cnt, m_hit);
    check("hitm_cnt", hitm_cnt, m_hitm);
    check("pending_events", exp_res.size() + exp_wb.size() + exp_upd.size(), 0);
  endtask
  initial begin
    res_t e;
    upd_t u;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      if (bus.proto_err) err_seen++;
      if (bus.lk_req) begin
        check("lk_index", bus.lk_index, cur_idx);
        check("lk_tag", bus.lk_tag, cur_tag);
      end
      if (bus.res_valid) begin
        if (exp_res.size() == 0) check("res_unexpected", bus.res_valid, 0);
        else begin
          e = exp_res.pop_front();
          check("res", bus.res, e.res);
          check("res_cycle", cyc, e.cyc);
        end
      end
      if (bus.wb_valid && bus.wb_ready) begin
        if (exp_wb.size() == 0) check("wb_unexpected", bus.wb_valid, 0);
        else begin
          a = exp_wb.pop_front();
          check("wb_addr", bus.wb_addr, a);
        end
      end
      if (bus.upd_valid) begin
        if (exp_upd.size() == 0) check("upd_unexpected", bus.upd_valid, 0);
        else begin
          u = exp_upd.pop_front();
          check("upd_index", bus.upd_index, u.idx);
          check("upd_way", bus.upd_way, u.way);
          check("upd_mesi", bus.upd_mesi, u.m);
        end
      end
    end
  end
  initial begin
    bus.lk_rsp_valid = 0; bus.lk_hit = 0; bus.lk_way = '0; bus.lk_mesi = MESI_I;
    forever begin
      @(posedge clk);
      #1;
      if (bus.lk_req) begin
        @(posedge clk);
        #1 bus.lk_rsp_valid = cur_rv; bus.lk_hit = cur_hit; bus.lk_way = cur_way; bus.lk_mesi = cur_mesi;
        @(posedge clk);
        #1 bus.lk_rsp_valid = 0; bus.lk_hit = 0; bus.lk_way = '0; bus.lk_mesi = MESI_I;
      end
    end
  end
  initial begin
    bus.wb_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wb_valid) begin
        bus.wb_ready = wb_wait >= cur_delay;
        wb_wait++;
      end else begin
        bus.wb_ready = 0;
        wb_wait = 0;
      end
    end
  end
  initial begin
    logic wb, chg, err;
    int n;
    bus.snp_valid = 0; bus.snp_op = OP_READ; bus.snp_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_upd_valid", bus.upd_valid, 0);
    check("rst_snp_cnt", snp_cnt, 0);
    rst_n = 1;
    do_snoop(OP_READ, 32'h12345678, 1, 1, 4'd5, MESI_M, 3);
    do_snoop(OP_RWIM, 32'h12345678, 1, 1, 4'd5, MESI_E, 0);
    do_snoop(OP_READ, 32'h0badf00d, 1, 0, 4'd0, MESI_I, 0);
    do_snoop(OP_INVALIDATE, 32'h00c0ffee, 1, 1, 4'd2, MESI_M, 0);
    do_snoop(OP_WRITE, 32'h7fff0040, 1, 1, 4'd9, MESI_S, 0);
    do_snoop(OP_READ, 32'h44440000, 0, 1, 4'd3, MESI_S, 0);
    launch(OP_READ, 32'hdeadbeef, 1, 1, 4'd7, MESI_M, 1000, wb, chg, err);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.wb_valid && n < 50);
    check("wb_reached", bus.wb_valid, 1);
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    check("arst_wb_valid", bus.wb_valid, 0);
    check("arst_upd_valid", bus.upd_valid, 0);
    check("arst_wb_addr", bus.wb_addr, 0);
    check("arst_snp_cnt", snp_cnt, 0);
    check("arst_hitm_cnt", hitm_cnt, 0);
    exp_wb.delete(); exp_upd.delete(); exp_res.delete();
    m_snp = 0; m_hit = 0; m_hitm = 0;
    cur_delay = 0;
    @(negedge clk);
    rst_n = 1;
    do_snoop(OP_READ, 32'h00001040, 1, 1, 4'd1, MESI_E, 0);
    for (int i = 0; i < 17; i++)
      do_snoop(OP_READ, $urandom, 1, 1, 4'($urandom), MESI_S, 0);
    check("hit_cnt_saturated", hit_cnt, CMAX);
    for (int i = 0; i < 40; i++) begin
      logic h;
      h = $urandom_range(0, 2) != 0;
      do_snoop(bus_op_e'($urandom_range(0, 3)), $urandom, $urandom_range(0, 7) != 0, h,
               4'($urandom), h ? mesi_states_e'($urandom_range(1, 3)) : MESI_I, $urandom_range(0, 4));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
